addsub_accum_ctrl: RTL and testbench
====================================

// Module: addsub_accum_ctrl
// PURPOSE
//  Sequencing/accumulator stage wrapped around the 4-bit adder_subtractor datapath.
//  Upstream side: accepts op commands over a valid/ready handshake and drives the adder inputs.
//  Downstream side: captures the adder's sum/cout into an accumulator, computes flags and
//  presents a result over a valid/ready handshake. One command in flight at a time.
// PARAMETERS
//  WIDTH     4  operand/accumulator width; must equal adder datapath width
// PORTS
//  clk        in   1      sole clock, all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  cmd_valid  in   1      command present
//  cmd_ready  out  1      block can accept a command (high only in IDLE)
//  cmd_op     in   2      00 LOAD, 01 ADD, 10 SUB, 11 CLR
//  cmd_data   in   WIDTH  operand B (LOAD: value to load)
//  as_a       out  WIDTH  to adder a: registered accumulator
//  as_b       out  WIDTH  to adder b: registered operand
//  as_m       out  1      to adder m: 1 = subtract
//  as_sum     in   WIDTH  from adder sum
//  as_cout    in   1      from adder cout
//  res_valid  out  1      result available
//  res_ready  in   1      consumer accepts result
//  res_data   out  WIDTH  accumulator value after the op
//  res_c      out  1      carry (ADD) / not-borrow (SUB: 1 means acc >= B unsigned)
//  res_v      out  1      signed two's-complement overflow
//  res_z      out  1      res_data == 0
// BEHAVIOUR
//  Reset: state IDLE; acc, opnd, as_m, res_data, res_c, res_v, res_z, res_valid = 0; cmd_ready=1.
//  FSM IDLE -> EXEC -> RESP -> IDLE.
//   IDLE: cmd_ready=1. On cmd_valid&&cmd_ready: opnd<=cmd_data, op_r<=cmd_op,
//         as_m<=(cmd_op==SUB); go EXEC.
//   EXEC: as_a=acc, as_b=opnd, as_m stable for full cycle (adder path is purely combinational).
//         At end of EXEC capture:
//           ADD/SUB: acc<=as_sum, res_c<=as_cout,
//                    res_v<=(as_a[MSB]==beff[MSB])&&(as_sum[MSB]!=as_a[MSB]), beff=as_b^{WIDTH{as_m}}
//           LOAD:    acc<=opnd, res_c<=0, res_v<=0
//           CLR:     acc<=0,    res_c<=0, res_v<=0
//         res_z from new acc value. go RESP.
//   RESP: res_valid=1, res_data=acc; all res_* held stable until res_ready; on res_ready go IDLE
//         (same edge). No new command accepted in RESP or EXEC (cmd_ready=0).
//  Latency: accept edge -> res_valid high 2 cycles later; min 3 cycles per command.
//  Wrap: ADD/SUB are modulo 2^WIDTH (0xF+0x1 -> 0x0, c=1); flags report, never alter, result.
//  cmd_valid in EXEC/RESP: ignored, command must be held by source (standard valid/ready).
//  rst mid-operation (any state): return to reset values next edge; in-flight command dropped.
//  as_a/as_b/as_m are registers (no combinational path from cmd_* to adder inputs).
// CONFIGURATION
//  ADDSUB_SAT_EN defined: ADD/SUB saturate in signed sense when overflow detected:
//   positive overflow -> acc = 0111..1, negative -> 1000..0; res_v still =1; res_c unchanged.
//  ADDSUB_SAT_EN undefined: wrap-around as above; no saturation logic present.
// STRUCTURE
//  Package addsub_pkg: op encodings (OP_LOAD/OP_ADD/OP_SUB/OP_CLR), FSM state encoding
//   (S_IDLE/S_EXEC/S_RESP), WIDTH default constant.
//  One sub-module: addsub_flags (combinational: as_a, as_b, as_m, as_sum, as_cout -> c, v,
//   saturated value). Adder itself is instantiated beside this block at top level, not inside it.
// TESTING (bench instantiates this block + adder_subtractor back-to-back)
//  1 rst high 2 cycles mid-EXEC -> all outputs 0, cmd_ready=1, res_valid=0 next cycle.
//  2 LOAD 0x5, ADD 0x3 -> res_data=0x8, c=0, v=1 (5+3 overflows signed 4-bit), z=0;
//    with ADDSUB_SAT_EN: res_data=0x7, v=1.
//  3 LOAD 0x3, SUB 0x3 -> res_data=0x0, c=1, v=0, z=1; then SUB 0x1 -> 0xF, c=0, v=0.
//  4 LOAD 0xF, ADD 0x1 -> res_data=0x0, c=1, v=0, z=1 (unsigned wrap).
//  5 LOAD 0x8, SUB 0x1 -> res_data=0x7, v=1 (w/ SAT_EN: 0x8); CLR -> 0x0, c=v=0, z=1.
//  6 Backpressure: hold res_ready=0 10 cycles -> res_* stable, cmd_ready=0, held cmd not taken;
//    release -> next command accepted the cycle after res handshake; latency exactly 2 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared encodings for the add/subtract accumulator controller.
// Optional signed saturation is enabled by defining ADDSUB_SAT_EN.
package addsub_pkg;

  localparam int unsigned ADDSUB_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/adder_subtractor.sv
// 4-bit style ripple adder/subtractor datapath: m=1 computes a - b as a + ~b + 1.
module adder_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] beff;

  always_comb begin
    beff        = b ^ {WIDTH{m}};
    {cout, sum} = {1'b0, a} + {1'b0, beff} + {{WIDTH{1'b0}}, m};
  end

endmodule

// File: rtl/addsub_flags.sv
// Carry/overflow flags and result value for the accumulator capture.
// With ADDSUB_SAT_EN defined the result saturates in the signed sense on overflow.
module addsub_flags
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
  input  logic [WIDTH-1:0] as_a,
  input  logic [WIDTH-1:0] as_b,
  input  logic             as_m,
  input  logic [WIDTH-1:0] as_sum,
  input  logic             as_cout,
  output logic             flag_c,
  output logic             flag_v,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] beff;

  always_comb begin
    beff   = as_b ^ {WIDTH{as_m}};
    flag_c = as_cout;
    flag_v = (as_a[WIDTH-1] == beff[WIDTH-1]) && (as_sum[WIDTH-1] != as_a[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
    // Operand sign tells the overflow direction: both negative means it went too low.
    if (flag_v) begin
      result = as_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      result = as_sum;
    end
`else
    result = as_sum;
`endif
  end

endmodule

// File: rtl/addsub_accum_ctrl.sv
// Command sequencer and accumulator around an external adder_subtractor.
// Honours ADDSUB_SAT_EN through the addsub_flags sub-module.
module addsub_accum_ctrl
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  output logic             as_m,
  input  logic [WIDTH-1:0] as_sum,
  input  logic             as_cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_c,
  output logic             res_v,
  output logic             res_z
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             m_q, m_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic             flag_c;
  logic             flag_v;
  logic [WIDTH-1:0] flag_result;

  addsub_flags #(.WIDTH(WIDTH)) u_flags (
    .as_a    (acc_q),
    .as_b    (opnd_q),
    .as_m    (m_q),
    .as_sum  (as_sum),
    .as_cout (as_cout),
    .flag_c  (flag_c),
    .flag_v  (flag_v),
    .result  (flag_result)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    m_d     = m_q;
    c_d     = c_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          opnd_d  = cmd_data;
          op_d    = op_e'(cmd_op);
          m_d     = (op_e'(cmd_op) == OP_SUB);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD, OP_SUB: begin
            acc_d = flag_result;
            c_d   = flag_c;
            v_d   = flag_v;
          end
          OP_LOAD: begin
            acc_d = opnd_q;
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
          default: begin
            acc_d = '0;
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
        endcase
        z_d     = (acc_d == '0);
        state_d = S_RESP;
      end
      S_RESP: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      acc_q   <= '0;
      opnd_q  <= '0;
      m_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      m_q     <= m_d;
      c_q     <= c_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_RESP);
  assign as_a      = acc_q;
  assign as_b      = opnd_q;
  assign as_m      = m_q;
  assign res_data  = acc_q;
  assign res_c     = c_q;
  assign res_v     = v_q;
  assign res_z     = z_q;

endmodule

// File: tb/tb_addsub_accum_ctrl.sv
// Scoreboard bench: controller wired back-to-back with adder_subtractor.
// Expectations follow ADDSUB_SAT_EN when it is defined.
module tb_addsub_accum_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] as_a, as_b, as_sum;
  logic         as_m, as_cout;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         res_c, res_v, res_z;

  int checks = 0;
  int failures = 0;
  int pushed = 0;
  int popped = 0;
  logic [6:0] exp_q[$];

  always #5 clk = ~clk;

  addsub_accum_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .as_a(as_a), .as_b(as_b), .as_m(as_m), .as_sum(as_sum), .as_cout(as_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_c(res_c), .res_v(res_v), .res_z(res_z)
  );

  adder_subtractor #(.WIDTH(W)) u_adder (
    .a(as_a), .b(as_b), .m(as_m), .sum(as_sum), .cout(as_cout)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one response transfer per negedge with valid&ready.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", 1, 0);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        popped++;
        chk("res_data", int'(res_data), int'(e[6:3]));
        chk("res_c", int'(res_c), int'(e[2]));
        chk("res_v", int'(res_v), int'(e[1]));
        chk("res_z", int'(res_z), int'(e[0]));
      end
    end
  end

  task automatic push_exp(input logic [W-1:0] d, input logic c, input logic v);
    exp_q.push_back({d, c, v, (d == '0)});
    pushed++;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        chk(name, 0, 1);
        break;
      end
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] d,
                      input logic [W-1:0] ed, input logic ec, input logic ev);
    @(posedge clk);
    #1;
    push_exp(ed, ec, ev);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    wait_ready("cmd_ready_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("exec_res_valid", int'(res_valid), 0);
    chk("exec_cmd_ready", int'(cmd_ready), 0);
    @(negedge clk);
    chk("latency_res_valid", int'(res_valid), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_flags", int'({res_c, res_v, res_z}), 0);

    // Reset mid-EXEC drops the in-flight command.
    send(2'b00, 4'h9, 4'h9, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'h4;
    wait_ready("rst_test_ready");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_cmd_ready", int'(cmd_ready), 1);
    chk("midrst_res_valid", int'(res_valid), 0);
    chk("midrst_res_data", int'(res_data), 0);
    chk("midrst_as", int'({as_a, as_b, as_m}), 0);
    chk("midrst_flags", int'({res_c, res_v, res_z}), 0);

    send(2'b00, 4'h5, 4'h5, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    send(2'b01, 4'h3, 4'h7, 1'b0, 1'b1);
`else
    send(2'b01, 4'h3, 4'h8, 1'b0, 1'b1);
`endif
    send(2'b00, 4'h3, 4'h3, 1'b0, 1'b0);
    send(2'b10, 4'h3, 4'h0, 1'b1, 1'b0);
    send(2'b10, 4'h1, 4'hF, 1'b0, 1'b0);
    send(2'b00, 4'hF, 4'hF, 1'b0, 1'b0);
    send(2'b01, 4'h1, 4'h0, 1'b1, 1'b0);
    send(2'b00, 4'h8, 4'h8, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    send(2'b10, 4'h1, 4'h8, 1'b1, 1'b1);
`else
    send(2'b10, 4'h1, 4'h7, 1'b1, 1'b1);
`endif
    send(2'b11, 4'h6, 4'h0, 1'b0, 1'b0);

    // Backpressure: response held, next command waits.
    @(posedge clk);
    #1 res_ready = 1'b0;
    send(2'b00, 4'h2, 4'h2, 1'b0, 1'b0);
    push_exp(4'h3, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'h1;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_res_data", int'(res_data), 2);
      chk("bp_flags", int'({res_c, res_v, res_z}), 0);
      chk("bp_cmd_ready", int'(cmd_ready), 0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_cmd_ready", int'(cmd_ready), 1);
    chk("bp_release_res_valid", int'(res_valid), 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_exec_ready", int'(cmd_ready), 0);
    chk("bp_next_exec_valid", int'(res_valid), 0);
    @(negedge clk);
    chk("bp_next_latency", int'(res_valid), 1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("responses_seen", popped, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
